// File: rtl/register_read_phase_pkg.sv
// Shared core package: register-file geometry, address/data types
// and a small address-match helper used by the read side and scoreboard.
package register_read_phase_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0]    raddr_t;
    typedef logic [XLEN-1:0]  xword_t;
    typedef logic [NREGS-1:0] busy_t;

    localparam raddr_t REG_ZERO = '0;

    function automatic logic addr_hit(
        input logic   en,
        input raddr_t wa,
        input raddr_t a
    );
        return en && (wa == a);
    endfunction

endpackage

// File: rtl/register_read_phase_scoreboard.sv
// Per-register busy scoreboard: tracks outstanding writes and
// raises a RAW/WAW stall until the matching writeback retires.
module reg_scoreboard
    import register_read_phase_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_wb_wen,
    input  raddr_t i_wb_waddr,
    input  logic   i_issue_valid,
    input  raddr_t i_rs1_addr,
    input  raddr_t i_rs2_addr,
    input  logic   i_rs1_used,
    input  logic   i_rs2_used,
    input  raddr_t i_rd_addr,
    input  logic   i_rd_wen,
    output logic   o_stall,
    output logic   o_issue_fire,
    output busy_t  o_busy_vec
);

    busy_t busy_q;
    busy_t busy_d;

    // A writeback landing this cycle already resolves the hazard.
    function automatic logic src_busy(
        input busy_t  b,
        input raddr_t a,
        input logic   wen,
        input raddr_t wa
    );
        return b[a] && !addr_hit(wen, wa, a) && (a != REG_ZERO);
    endfunction

    logic hz_rs1;
    logic hz_rs2;
    logic hz_rd;
    logic stall;
    logic fire;

    always_comb begin
        hz_rs1 = i_rs1_used &&
                 src_busy(busy_q, i_rs1_addr, i_wb_wen, i_wb_waddr);
        hz_rs2 = i_rs2_used &&
                 src_busy(busy_q, i_rs2_addr, i_wb_wen, i_wb_waddr);
        hz_rd  = i_rd_wen &&
                 src_busy(busy_q, i_rd_addr, i_wb_wen, i_wb_waddr);
        stall  = i_issue_valid && (hz_rs1 || hz_rs2 || hz_rd);
        fire   = i_issue_valid && !stall;
    end

    // Set wins over clear so a re-issue reclaims a retiring register.
    always_comb begin
        busy_d = busy_q;
        for (int n = 1; n < NREGS; n++) begin
            if (fire && i_rd_wen && (i_rd_addr == raddr_t'(n))) begin
                busy_d[n] = 1'b1;
            end else if (addr_hit(i_wb_wen, i_wb_waddr, raddr_t'(n))) begin
                busy_d[n] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_stall      = stall;
    assign o_issue_fire = fire;
    assign o_busy_vec   = busy_q;

endmodule

// File: rtl/register_read_phase.sv
// Register-file read side: architectural storage, two bypassed
// combinational read ports, and the issue hazard scoreboard.
module register_read_phase
    import register_read_phase_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wb_wen,
    input  logic [AW-1:0]    i_wb_waddr,
    input  logic [XLEN-1:0]  i_wb_wdata,
    input  logic             i_issue_valid,
    input  logic [AW-1:0]    i_rs1_addr,
    input  logic [AW-1:0]    i_rs2_addr,
    input  logic             i_rs1_used,
    input  logic             i_rs2_used,
    input  logic [AW-1:0]    i_rd_addr,
    input  logic             i_rd_wen,
    output logic [XLEN-1:0]  o_rs1_data,
    output logic [XLEN-1:0]  o_rs2_data,
    output logic             o_stall,
    output logic             o_issue_fire,
    output logic [NREGS-1:0] o_busy_vec
);

    xword_t regs_q [NREGS];
    logic   wr_en;

    function automatic xword_t rd_port(
        input raddr_t a,
        input xword_t stored,
        input logic   wen,
        input raddr_t wa,
        input xword_t wd
    );
        xword_t r;
        r = stored;
        if (a == REG_ZERO) begin
            r = '0;
        end else if (addr_hit(wen, wa, a)) begin
            r = wd;
        end
        return r;
    endfunction

    assign wr_en = i_wb_wen && (i_wb_waddr != REG_ZERO);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[i_wb_waddr] <= i_wb_wdata;
        end
    end

    always_comb begin
        o_rs1_data = rd_port(i_rs1_addr, regs_q[i_rs1_addr],
                             i_wb_wen, i_wb_waddr, i_wb_wdata);
        o_rs2_data = rd_port(i_rs2_addr, regs_q[i_rs2_addr],
                             i_wb_wen, i_wb_waddr, i_wb_wdata);
    end

    reg_scoreboard u_sb (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_wb_wen      (i_wb_wen),
        .i_wb_waddr    (i_wb_waddr),
        .i_issue_valid (i_issue_valid),
        .i_rs1_addr    (i_rs1_addr),
        .i_rs2_addr    (i_rs2_addr),
        .i_rs1_used    (i_rs1_used),
        .i_rs2_used    (i_rs2_used),
        .i_rd_addr     (i_rd_addr),
        .i_rd_wen      (i_rd_wen),
        .o_stall       (o_stall),
        .o_issue_fire  (o_issue_fire),
        .o_busy_vec    (o_busy_vec)
    );

endmodule
